// File: rtl/rsa_modexp_engine.sv
// Modular exponentiation C = P^E mod M: right-to-left square-and-multiply on two bit-serial
// radix-2 Montgomery multipliers. Optional macro RSA_EARLY_EXIT_EN enables variable-time loop exit.
module rsa_modexp_engine #(
   parameter int WIDTH = 8,
   parameter int EXP_W = WIDTH
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             en,
   input  logic             start,
   input  logic [WIDTH-1:0] P,
   input  logic [EXP_W-1:0] E,
   input  logic [WIDTH-1:0] M,
   input  logic [WIDTH-1:0] Const,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] C
);
   localparam int DW   = WIDTH + 2;
   localparam int RW   = WIDTH + 3;
   localparam int CW   = $clog2(DW + 1);
   localparam int RNDW = $clog2(EXP_W + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_PRE, S_LOOP, S_POST, S_REDUCE, S_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt;
   logic [RNDW-1:0]   rnd;
   logic [WIDTH-1:0]  p_q, m_q, k_q;
   logic [EXP_W-1:0]  e_q;
   logic [DW-1:0]     a_q, x_q;
   logic [DW-1:0]     m0_a, m0_b, m0_r, m1_a, m1_b, m1_r;
   logic [DW-1:0]     ld0_a, ld0_b, ld1_a, ld1_b;
   logic [DW-1:0]     m0_next, m1_next, red;
   logic              accept, round_end, loop_last, in_round;

   // One Montgomery iteration; the sum needs WIDTH+3 bits, the halved result fits in WIDTH+2.
   function automatic logic [DW-1:0] mont_step(input logic [DW-1:0] r, input logic a_bit,
                                               input logic [DW-1:0] b, input logic [WIDTH-1:0] m);
      logic [RW-1:0] t;
      t = RW'(r) + (a_bit ? RW'(b) : '0);
      if (t[0])
         t = t + RW'(m);
      return t[RW-1:1];
   endfunction

   assign accept    = (state == S_IDLE) && start;
   assign round_end = (cnt == CW'(DW));
   assign in_round  = (state == S_PRE) || (state == S_LOOP) || (state == S_POST);
   assign m0_next   = mont_step(m0_r, m0_a[0], m0_b, m_q);
   assign m1_next   = mont_step(m1_r, m1_a[0], m1_b, m_q);
   assign red       = (a_q >= DW'(m_q)) ? a_q - DW'(m_q) : a_q;

`ifdef RSA_EARLY_EXIT_EN
   assign loop_last = ((e_q >> 1) == '0);
`else
   assign loop_last = (rnd == RNDW'(EXP_W - 1));
`endif

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb)
         state <= S_IDLE;
      else if (en)
         state <= state_nxt;
   end

   // Even modulus routes through REDUCE so error completion keeps the uniform CHECK/REDUCE/DONE tail.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_CHECK;
         S_CHECK:  state_nxt = m_q[0] ? S_PRE : S_REDUCE;
         S_PRE: begin
            if (round_end) begin
`ifdef RSA_EARLY_EXIT_EN
               state_nxt = (e_q == '0) ? S_POST : S_LOOP;
`else
               state_nxt = S_LOOP;
`endif
            end
         end
         S_LOOP:   if (round_end && loop_last) state_nxt = S_POST;
         S_POST:   if (round_end) state_nxt = S_REDUCE;
         S_REDUCE: state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      ld0_a = a_q;
      ld0_b = DW'(1);
      ld1_a = a_q;
      ld1_b = DW'(1);
      case (state)
         S_PRE: begin
            ld0_a = DW'(p_q);
            ld0_b = DW'(k_q);
            ld1_a = DW'(k_q);
            ld1_b = DW'(1);
         end
         S_LOOP: begin
            ld0_a = x_q;
            ld0_b = x_q;
            ld1_a = a_q;
            ld1_b = x_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cnt  <= '0;
         rnd  <= '0;
         p_q  <= '0;
         m_q  <= '0;
         k_q  <= '0;
         e_q  <= '0;
         a_q  <= '0;
         x_q  <= '0;
         m0_a <= '0;
         m0_b <= '0;
         m0_r <= '0;
         m1_a <= '0;
         m1_b <= '0;
         m1_r <= '0;
      end else if (en) begin
         if (accept) begin
            p_q <= P;
            e_q <= E;
            m_q <= M;
            k_q <= Const;
            a_q <= '0;
            x_q <= '0;
            cnt <= '0;
            rnd <= '0;
         end else if (in_round) begin
            if (cnt == '0) begin
               m0_a <= ld0_a;
               m0_b <= ld0_b;
               m1_a <= ld1_a;
               m1_b <= ld1_b;
               m0_r <= '0;
               m1_r <= '0;
               cnt  <= CW'(1);
            end else begin
               m0_r <= m0_next;
               m1_r <= m1_next;
               m0_a <= m0_a >> 1;
               m1_a <= m1_a >> 1;
               if (round_end) begin
                  cnt <= '0;
                  case (state)
                     S_PRE: begin
                        x_q <= m0_next;
                        a_q <= m1_next;
                     end
                     S_LOOP: begin
                        x_q <= m0_next;
                        if (e_q[0])
                           a_q <= m1_next;
                        e_q <= e_q >> 1;
                        rnd <= rnd + RNDW'(1);
                     end
                     default: a_q <= m1_next;
                  endcase
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         busy <= 1'b0;
         done <= 1'b0;
         err  <= 1'b0;
         C    <= '0;
      end else if (en) begin
         done <= (state == S_REDUCE);
         if (accept) begin
            busy <= 1'b1;
            err  <= 1'b0;
         end
         if (state == S_REDUCE) begin
            busy <= 1'b0;
            err  <= ~m_q[0];
            C    <= m_q[0] ? red[WIDTH-1:0] : '0;
         end
      end
   end

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Bench for rsa_modexp_engine (WIDTH=EXP_W=8): vector table, corner-case sequences and
// random jobs checked against a plain-arithmetic modular exponentiation model.
module tb_rsa_modexp_engine;
   logic       clk = 1'b0;
   logic       rstb, en, start;
   logic [7:0] P, E, M, Const;
   logic       busy, done, err;
   logic [7:0] C;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   rsa_modexp_engine #(.WIDTH(8), .EXP_W(8)) dut (
      .clk(clk), .rstb(rstb), .en(en), .start(start),
      .P(P), .E(E), .M(M), .Const(Const),
      .busy(busy), .done(done), .err(err), .C(C)
   );

   typedef struct {
      int p;
      int e;
      int m;
      int c;
      int er;
      int lat;
   } vec_t;

   vec_t vecs[9];

   function automatic int ref_modexp(input int p, input int e, input int m);
      longint r, b;
      r = 1 % m;
      b = p % m;
      for (int i = 0; i < 8; i++) begin
         if (e[i])
            r = (r * b) % m;
         b = (b * b) % m;
      end
      return int'(r);
   endfunction

   function automatic int const_of(input int m);
      return (1 << 20) % m;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // mode 0: plain job; 1: stray start + new inputs at cycle 40; 2: en low cycles 30..39;
   // 3: reset asserted at cycle 50 (job aborted, no done).
   task automatic run_job(input int p, input int e, input int m, input int mode,
                          output int lat, output int c_out, output int e_out, output int busy_d);
      int cyc;
      @(negedge clk);
      P = 8'(p);
      E = 8'(e);
      M = 8'(m);
      Const = 8'(const_of(m));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      lat = -1;
      c_out = -1;
      e_out = -1;
      busy_d = -1;
      chk("busy_after_accept", int'(busy), 1);
      while (!done && cyc < 400) begin
         if (mode == 1 && cyc == 40) begin
            start = 1'b1;
            P = 8'd7;
            E = 8'd200;
            M = 8'd99;
            Const = 8'(const_of(99));
         end
         if (mode == 1 && cyc == 41)
            start = 1'b0;
         if (mode == 2 && cyc == 30)
            en = 1'b0;
         if (mode == 2 && cyc == 40)
            en = 1'b1;
         if (mode == 3 && cyc == 50) begin
            rstb = 1'b0;
            #1;
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_err", int'(err), 0);
            chk("rst_c", int'(C), 0);
            @(negedge clk);
            rstb = 1'b1;
            return;
         end
         @(negedge clk);
         cyc++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no done after %0d cycles, required within 400", cyc);
      end
      lat = cyc;
      c_out = int'(C);
      e_out = int'(err);
      busy_d = int'(busy);
   endtask

   initial begin
      int lat, c_out, e_out, busy_d, p, e, m;
      rstb = 1'b0;
      en = 1'b1;
      start = 1'b0;
      P = '0;
      E = '0;
      M = '0;
      Const = '0;

      vecs[0] = '{4,   13, 77,  53, 0, 113};
      vecs[1] = '{200, 1,  77,  46, 0, 113};
      vecs[2] = '{5,   0,  77,  1,  0, 113};
      vecs[3] = '{9,   7,  1,   0,  0, 113};
      vecs[4] = '{0,   5,  77,  0,  0, 113};
      vecs[5] = '{3,   4,  76,  0,  1, 3};
      vecs[6] = '{10,  3,  77,  76, 0, 113};
      vecs[7] = '{2,   10, 255, 4,  0, 113};
      vecs[8] = '{0,   0,  77,  1,  0, 113};

      repeat (2) @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_err", int'(err), 0);
      chk("reset_c", int'(C), 0);
      rstb = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_job(vecs[i].p, vecs[i].e, vecs[i].m, 0, lat, c_out, e_out, busy_d);
         chk($sformatf("vec%0d_c", i), c_out, vecs[i].c);
         chk($sformatf("vec%0d_err", i), e_out, vecs[i].er);
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("vec%0d_busy_at_done", i), busy_d, 0);
         @(negedge clk);
         chk($sformatf("vec%0d_done_pulse", i), int'(done), 0);
      end

      run_job(4, 13, 77, 1, lat, c_out, e_out, busy_d);
      chk("restart_ignored_c", c_out, 53);
      chk("restart_ignored_latency", lat, 113);

      run_job(10, 3, 77, 2, lat, c_out, e_out, busy_d);
      chk("en_stall_c", c_out, 76);
      chk("en_stall_latency", lat, 123);

      run_job(4, 13, 77, 3, lat, c_out, e_out, busy_d);
      run_job(200, 1, 77, 0, lat, c_out, e_out, busy_d);
      chk("after_reset_c", c_out, 46);
      chk("after_reset_latency", lat, 113);

      for (int i = 0; i < 12; i++) begin
         p = int'($urandom_range(0, 255));
         e = int'($urandom_range(0, 255));
         m = 2 * int'($urandom_range(1, 127)) + 1;
         run_job(p, e, m, 0, lat, c_out, e_out, busy_d);
         chk($sformatf("rand%0d_c(p=%0d,e=%0d,m=%0d)", i, p, e, m), c_out, ref_modexp(p, e, m));
         chk($sformatf("rand%0d_err", i), e_out, 0);
         chk($sformatf("rand%0d_latency", i), lat, 113);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
